// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the multi-cycle core's fetch stage.
// Holds the fetch state enum, sticky error codes and the default boot address.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Word-aligned targets are the only legal ones; callers pass just the low bits.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory port between the fetch unit (master) and the memory (slave).
interface pc_fetch_unit_if;

  // Handshake: imem_req is the valid; imem_addr is held stable while imem_req is
  // high. imem_ack is a one-cycle response that completes the request in the
  // cycle it is sampled, with imem_rdata valid alongside it. A request may be
  // dropped without an ack only by reset; the memory must tolerate that.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_unit.sv
// Architectural PC holder and instruction fetcher for the multi-cycle core.
// Fetches the word at pc, holds it for decode, commits next_pc on retire.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            next_pc,
  input  logic                   pc_load,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            pc,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  output logic [1:0]             err_code,
  output logic [31:0]            retire_count,
  output fetch_state_t           dbg_state
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [1:0]   err_q;
  logic [31:0]  retire_q;
  logic [15:0]  timer_q;
  logic         req_q;
  logic         valid_q;

  // req/valid are flops set alongside the state so they drop straight on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      err_q    <= ERR_NONE;
      retire_q <= '0;
      timer_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_FETCH;
          req_q <= 1'b1;
        end
        ST_FETCH: begin
          // An ack on the last allowed cycle still completes the fetch.
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            timer_q <= '0;
            state   <= ST_VALID;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end else if (timer_q == TIMER_LAST) begin
            err_q <= ERR_TIMEOUT;
            state <= ST_ERROR;
            req_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        ST_VALID: begin
          if (pc_load) begin
            retire_q <= retire_q + 32'd1;
            pc_q     <= next_pc;
            valid_q  <= 1'b0;
            // A bad target is still committed so it can be inspected.
            if (is_word_aligned(next_pc[1:0])) begin
              state <= ST_FETCH;
              req_q <= 1'b1;
            end else begin
              err_q <= ERR_MISALIGN;
              state <= ST_ERROR;
            end
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state   <= ST_ERROR;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign err_code       = err_q;
  assign retire_count   = retire_q;
  assign dbg_state      = state;

  a_req_valid_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(req_q && valid_q));
  a_addr_stable_until_ack: assert property (@(posedge clk) disable iff (reset)
    (req_q && !imem.imem_ack) |=> $stable(pc_q));
  a_error_is_sticky: assert property (@(posedge clk) disable iff (reset)
    (state == ST_ERROR) |=> (state == ST_ERROR) && $stable(err_q) && $stable(pc_q));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the fetch loop.
module tb_pc_fetch_unit;
  import mips_fetch_pkg::*;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] RPC     = 32'h0000_3000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  next_pc = '0;
  logic         pc_load = 1'b0;
  logic [31:0]  pc, instr, retire_count;
  logic         instr_valid;
  logic [1:0]   err_code;
  fetch_state_t dbg_state;

  pc_fetch_unit_if mem_if ();

  pc_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .pc_load      (pc_load),
    .imem         (mem_if),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .err_code     (err_code),
    .retire_count (retire_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];   // fetch addresses in the order they must be requested

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model thinks in terms of "waiting for memory", "holding a word",
  // "dead" and counts how long memory has kept us waiting.
  localparam int M_BOOT = 0, M_WAIT = 1, M_HOLD = 2, M_DEAD = 3;
  int          m_phase  = M_BOOT;
  int          m_waited = 0;
  logic [31:0] m_pc     = RPC;
  logic [31:0] m_instr  = '0;
  logic [1:0]  m_err    = 2'b00;
  logic [31:0] m_ret    = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  <= M_BOOT;
      m_waited <= 0;
      m_pc     <= RPC;
      m_instr  <= '0;
      m_err    <= 2'b00;
      m_ret    <= '0;
      exp_q.delete();
    end else if (m_phase == M_BOOT) begin
      m_phase <= M_WAIT;
      exp_q.push_back(m_pc);
    end else if (m_phase == M_WAIT) begin
      if (mem_if.imem_ack) begin
        m_instr  <= mem_if.imem_rdata;
        m_waited <= 0;
        m_phase  <= M_HOLD;
      end else if (m_waited + 1 >= TIMEOUT) begin
        m_err   <= 2'b10;
        m_phase <= M_DEAD;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (m_phase == M_HOLD && pc_load) begin
      m_ret <= m_ret + 32'd1;
      m_pc  <= next_pc;
      if (next_pc % 4 != 0) begin
        m_err   <= 2'b01;
        m_phase <= M_DEAD;
      end else begin
        m_phase <= M_WAIT;
        exp_q.push_back(next_pc);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_req <= 1'b0;
    end else begin
      check("imem_req",     32'(mem_if.imem_req), 32'(m_phase == M_WAIT));
      check("instr_valid",  32'(instr_valid),     32'(m_phase == M_HOLD));
      check("pc",           pc,                   m_pc);
      check("imem_addr",    mem_if.imem_addr,     m_pc);
      check("instr",        instr,                m_instr);
      check("err_code",     32'(err_code),        32'(m_err));
      check("retire_count", retire_count,         m_ret);
      if (mem_if.imem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL fetch_order: got request at %h expected no request", mem_if.imem_addr);
        end else begin
          check("fetch_order", mem_if.imem_addr, exp_q.pop_front());
        end
      end
      prev_req <= mem_if.imem_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic ld, input logic [31:0] npc, input logic ack, input logic [31:0] rd);
    pc_load           = ld;
    next_pc           = npc;
    mem_if.imem_ack   = ack;
    mem_if.imem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    pc_load         = 1'b0;
    mem_if.imem_ack = 1'b0;
    reset           = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_cyc(input int load_pct, input logic allow_misalign);
    logic [31:0] npc;
    npc = $urandom();
    if (!allow_misalign) npc = npc & 32'hFFFF_FFFC;
    cyc(32'($urandom_range(0, 99)) < 32'(load_pct), npc, 1'($urandom_range(0, 1)), $urandom());
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] seq_addr[4] = '{32'h0000_3004, 32'h0000_3008, 32'h0000_300C, 32'h0000_3010};

  initial begin
    mem_if.imem_ack   = 1'b0;
    mem_if.imem_rdata = '0;
    @(negedge clk);
    check("reset_req", 32'(mem_if.imem_req), 32'd0);
    check("reset_pc",  pc, RPC);
    do_reset();

    // reset release and first fetch
    check("boot_req", 32'(mem_if.imem_req), 32'd0);
    cyc(0, '0, 0, '0);
    check("first_req",  32'(mem_if.imem_req), 32'd1);
    check("first_addr", mem_if.imem_addr, 32'h0000_3000);
    cyc(0, '0, 1, 32'h3C01_0001);
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_instr", instr, 32'h3C01_0001);

    // sequential retire at two cycles per instruction
    for (int i = 0; i < 3; i++) begin
      cyc(1, seq_addr[i], 0, '0);
      check("seq_addr", mem_if.imem_addr, seq_addr[i]);
      cyc(0, '0, 1, $urandom());
      check("seq_valid", 32'(instr_valid), 32'd1);
    end
    check("seq_retire", retire_count, 32'd3);

    // jump, then spurious pc_load in FETCH and spurious ack in VALID
    cyc(1, 32'h0040_0020, 0, '0);
    check("jump_addr", mem_if.imem_addr, 32'h0040_0020);
    cyc(1, 32'h0000_5000, 0, '0);
    check("spur_load_pc",     pc, 32'h0040_0020);
    check("spur_load_retire", retire_count, 32'd4);
    cyc(0, '0, 1, 32'h2402_0005);
    cyc(0, '0, 1, 32'hDEAD_BEEF);
    check("spur_ack_instr", instr, 32'h2402_0005);
    check("spur_ack_valid", 32'(instr_valid), 32'd1);

    // random traffic with aligned targets
    repeat (400) rand_cyc(35, 1'b0);

    // misaligned target
    do_reset();
    cyc(0, '0, 0, '0);
    cyc(0, '0, 1, 32'h3C01_0001);
    cyc(1, 32'h0000_3002, 0, '0);
    check("mis_err",   32'(err_code), 32'd1);
    check("mis_pc",    pc, 32'h0000_3002);
    check("mis_req",   32'(mem_if.imem_req), 32'd0);
    check("mis_valid", 32'(instr_valid), 32'd0);
    repeat (12) rand_cyc(50, 1'b1);
    check("mis_hold_err", 32'(err_code), 32'd1);
    check("mis_hold_pc",  pc, 32'h0000_3002);
    check("mis_hold_req", 32'(mem_if.imem_req), 32'd0);

    // timeout after exactly TIMEOUT fetch cycles
    do_reset();
    cyc(0, '0, 0, '0);
    repeat (TIMEOUT - 1) cyc(0, '0, 0, '0);
    check("to_pre_err", 32'(err_code), 32'd0);
    check("to_pre_req", 32'(mem_if.imem_req), 32'd1);
    cyc(0, '0, 0, '0);
    check("to_err",   32'(err_code), 32'd2);
    check("to_req",   32'(mem_if.imem_req), 32'd0);
    check("to_valid", 32'(instr_valid), 32'd0);

    // ack on the last allowed cycle wins
    do_reset();
    cyc(0, '0, 0, '0);
    repeat (TIMEOUT - 1) cyc(0, '0, 0, '0);
    cyc(0, '0, 1, 32'h1111_2222);
    check("late_ack_valid", 32'(instr_valid), 32'd1);
    check("late_ack_err",   32'(err_code), 32'd0);
    check("late_ack_instr", instr, 32'h1111_2222);

    // reset in the middle of a pending fetch at 0x3010
    do_reset();
    cyc(0, '0, 0, '0);
    cyc(0, '0, 1, $urandom());
    for (int i = 0; i < 4; i++) begin
      cyc(1, seq_addr[i], 0, '0);
      if (i < 3) cyc(0, '0, 1, $urandom());
    end
    repeat (3) cyc(0, '0, 0, '0);
    check("mid_addr", mem_if.imem_addr, 32'h0000_3010);
    check("mid_req",  32'(mem_if.imem_req), 32'd1);
    #2 reset = 1'b1;
    #1 check("mid_req_drop", 32'(mem_if.imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, '0, 0, '0);
    check("restart_addr",   mem_if.imem_addr, 32'h0000_3000);
    check("restart_retire", retire_count, 32'd0);
    check("restart_req",    32'(mem_if.imem_req), 32'd1);
    cyc(0, '0, 1, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Holds the architectural PC and fetches instructions from a handshaked instruction memory. It consumes the next-PC value computed by the PC calculation logic and returns each fetched word to the decode/execute stage. It polices target alignment and memory response time, and counts retired instructions. It sits between the PC calculator and the instruction memory port of the multi-cycle core.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles in FETCH without `imem_ack` (legal range 2..65535).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- next_pc  in  32  next PC from the PC calculator; sampled only when `pc_load` is accepted.
- pc_load  in  1  current instruction retired; commit `next_pc`.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals `pc`.
- imem_ack  in  1  memory response valid.
- imem_rdata  in  32  instruction word; valid with `imem_ack`.
- pc  out  32  current PC.
- instr  out  32  latched instruction for `pc`.
- instr_valid  out  1  `instr` holds the word for the current `pc`.
- err_code  out  2  sticky error: 00 none, 01 misaligned target, 10 fetch timeout.
- retire_count  out  32  number of accepted `pc_load` events; wraps.

## Operation
- States: BOOT, FETCH, VALID, ERROR.
- Reset (async, any state) gives:
  - state=BOOT, pc=RESET_PC, instr=0, err_code=00, retire_count=0, timer=0.
  - All outputs are decoded from registered state, so `imem_req` and `instr_valid` are 0 while reset is high.
- BOOT: lasts one cycle, then goes to FETCH. Reset released at edge N gives BOOT through N+1 and FETCH from N+1.
- FETCH:
  - `imem_req`=1 and `imem_addr`=pc; both are stable until ack.
  - On `imem_ack`: instr<=imem_rdata, timer<=0, go to VALID.
  - No ack: timer increments.
  - If timer==TIMEOUT-1 and there is no ack: err_code<=10, go to ERROR.
  - An ack in the same cycle the limit is reached wins; it is not an error.
- VALID:
  - `instr_valid`=1 and `imem_req`=0.
  - On `pc_load`: retire_count+=1 (mod 2^32) and pc<=next_pc.
  - If next_pc[1:0]!=0: err_code<=01, go to ERROR. pc still takes the bad value so it is visible for debug.
  - Otherwise go to FETCH.
- ERROR: `imem_req`=0 and `instr_valid`=0. All registers are frozen. Only reset exits.
- Ignored events:
  - `pc_load` outside VALID is ignored and does not count.
  - `imem_ack` outside FETCH is ignored; `instr` is unchanged.
- No arithmetic is performed on the PC here. PC+4, branch and jump targets all come from the PC calculator via `next_pc`.

## Timing
- Minimum per-instruction period is 2 cycles:
  - Ack arrives in the first FETCH cycle at edge E, so `instr_valid` is high from E.
  - `pc_load` at edge E+1 makes `imem_req` high from E+1 with the new address.
- Fetch latency: `instr_valid` rises on the edge that samples `imem_ack`=1.
- `pc`, `imem_addr` and `retire_count` change only on an accepted `pc_load` edge, or on reset.
- Timeout fires on the TIMEOUT-th consecutive FETCH cycle without ack.
- Reset asserted mid-FETCH drops `imem_req` immediately (asynchronously). The memory must tolerate an abandoned request.

## Structure
- Shared package `mips_fetch_pkg` holds:
  - the state enum;
  - the err_code constants ERR_NONE/ERR_MISALIGN/ERR_TIMEOUT;
  - the default RESET_PC.
- Single module; no sub-module is required. The timeout counter is a 16-bit register kept inline.

## Test plan
- Reset release: `imem_req`=0 in BOOT, then `imem_req`=1 with `imem_addr`=0x00003000 one cycle later. Ack with 0x3C010001 gives `instr_valid`=1 and `instr`=0x3C010001.
- Sequential retire: three `pc_load` events with next_pc 0x3004, 0x3008, 0x300C and 1-cycle acks. Required: addresses follow in order, 2 cycles per instruction, `retire_count`=3.
- Jump and spurious inputs:
  - `pc_load` with next_pc=0x00400020 gives the next request at 0x00400020.
  - A `pc_load` pulse during FETCH and an `imem_ack` pulse during VALID change nothing.
- Misaligned target: `pc_load` with next_pc=0x00003002 gives err_code=01, pc=0x00003002, req=0 and valid=0. These hold for 10+ cycles until reset.
- Timeout (TIMEOUT=16):
  - Withholding ack gives err_code=10 after exactly 16 FETCH cycles.
  - Repeating with ack in the 16th cycle gives VALID and no error.
- Reset mid-operation: assert reset during a wait with pc=0x3010. `imem_req` falls immediately, and after release the fetch restarts at 0x3000 with `retire_count`=0.
